wb_retire_queue: RTL and testbench

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

---
 rtl/wb_retire_queue.sv | 153 +++++++++++++++
 tb/tb_wb_retire_queue.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_retire_queue.sv
// Writeback-to-retire queue: epoch-filtered FIFO between execute and ROB/PRF.
// Optional macro WB_RETIRE_QUEUE_BYPASS_EN adds a zero-latency empty-queue path.
module wb_retire_queue #(
  parameter int DEPTH   = 4,
  parameter int ROB_W   = 6,
  parameter int PHYS_W  = 7,
  parameter int EPOCH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROB_W-1:0]   in_rob_idx,
  input  logic [EPOCH_W-1:0] in_epoch,
  input  logic [PHYS_W-1:0]  in_prd,
  input  logic               in_uses_rd,
  input  logic [31:0]        in_data,
  input  logic [31:0]        in_pc,
  input  logic               flush_valid,
  input  logic               recover_valid,
  input  logic [EPOCH_W-1:0] recover_epoch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROB_W-1:0]   out_rob_idx,
  output logic [EPOCH_W-1:0] out_epoch,
  output logic [31:0]        out_pc,
  output logic               prf_we,
  output logic [PHYS_W-1:0]  prf_waddr,
  output logic [31:0]        prf_wdata,
  output logic               wake_valid,
  output logic [PHYS_W-1:0]  wake_pd,
  output logic [15:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROB_W-1:0]   rob_idx;
    logic [EPOCH_W-1:0] epoch;
    logic [PHYS_W-1:0]  prd;
    logic               uses_rd;
    logic [31:0]        data;
    logic [31:0]        pc;
  } ent_t;

  ent_t               mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [EPOCH_W-1:0] live_epoch;
  logic               rdy;

  ent_t               in_ent;
  ent_t               hd;
  ent_t               sel;
  logic [EPOCH_W-1:0] eff_epoch;
  logic               stale;
  logic               in_fire;
  logic               q_live;
  logic               push;
  logic               q_pop;
  logic               head_drop;
  logic               in_drop;
  logic               out_fire;
  logic               q_adv;
  logic [1:0]         inc;
  logic [16:0]        sum;

  assign in_ent = '{
    rob_idx: in_rob_idx,
    epoch:   in_epoch,
    prd:     in_prd,
    uses_rd: in_uses_rd,
    data:    in_data,
    pc:      in_pc
  };
  assign hd        = mem[head];
  assign eff_epoch = recover_valid ? recover_epoch : live_epoch;
  assign stale     = in_epoch != eff_epoch;
  // rdy keeps in_ready low until the first edge after reset release
  assign in_ready  = rdy && (count != CNT_W'(DEPTH));
  assign in_fire   = in_valid && in_ready;
  assign q_live    = (count != '0) && (hd.epoch == live_epoch);

  always_comb begin
    out_valid = 1'b0;
    sel       = hd;
    q_pop     = 1'b0;
    head_drop = 1'b0;
    in_drop   = 1'b0;
    push      = 1'b0;
    if (!flush_valid) begin
      in_drop   = in_fire && stale;
      push      = in_fire && !stale;
      head_drop = (count != '0) && !q_live;
      if (q_live) begin
        out_valid = 1'b1;
        q_pop     = out_ready;
      end
`ifdef WB_RETIRE_QUEUE_BYPASS_EN
      else if ((count == '0) && push) begin
        out_valid = 1'b1;
        sel       = in_ent;
        push      = !out_ready;
      end
`endif
    end
  end

  assign out_fire    = out_valid && out_ready;
  assign out_rob_idx = sel.rob_idx;
  assign out_epoch   = sel.epoch;
  assign out_pc      = sel.pc;
  assign prf_we      = out_fire && sel.uses_rd;
  assign prf_waddr   = sel.prd;
  assign prf_wdata   = sel.data;
  assign wake_valid  = prf_we;
  assign wake_pd     = sel.prd;

  assign q_adv = q_pop || head_drop;
  assign inc   = {1'b0, in_drop} + {1'b0, head_drop};
  assign sum   = {1'b0, drop_cnt} + 17'(inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      live_epoch <= '0;
      drop_cnt   <= '0;
      rdy        <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (recover_valid) live_epoch <= recover_epoch;
      drop_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
      if (flush_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)  tail <= tail + PTR_W'(1);
        if (q_adv) head <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(q_adv);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_ent;
  end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Directed bench for wb_retire_queue: ordering, PRF write, recovery,
// flush, mid-stream reset and first-result latency.
module tb_wb_retire_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_rob_idx;
  logic [1:0]  in_epoch;
  logic [6:0]  in_prd;
  logic        in_uses_rd;
  logic [31:0] in_data;
  logic [31:0] in_pc;
  logic        flush_valid;
  logic        recover_valid;
  logic [1:0]  recover_epoch;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_rob_idx;
  logic [1:0]  out_epoch;
  logic [31:0] out_pc;
  logic        prf_we;
  logic [6:0]  prf_waddr;
  logic [31:0] prf_wdata;
  logic        wake_valid;
  logic [6:0]  wake_pd;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_retire_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rob_idx(in_rob_idx), .in_epoch(in_epoch),
    .in_prd(in_prd), .in_uses_rd(in_uses_rd),
    .in_data(in_data), .in_pc(in_pc),
    .flush_valid(flush_valid),
    .recover_valid(recover_valid),
    .recover_epoch(recover_epoch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_idx(out_rob_idx), .out_epoch(out_epoch),
    .out_pc(out_pc),
    .prf_we(prf_we), .prf_waddr(prf_waddr),
    .prf_wdata(prf_wdata),
    .wake_valid(wake_valid), .wake_pd(wake_pd),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_rob_idx    = '0;
    in_epoch      = '0;
    in_prd        = '0;
    in_uses_rd    = 1'b0;
    in_data       = '0;
    in_pc         = '0;
    flush_valid   = 1'b0;
    recover_valid = 1'b0;
    recover_epoch = '0;
    out_ready     = 1'b0;
  endtask

  task automatic drive(input int rob, input int ep, input int prd,
                       input bit uses, input logic [31:0] data);
    in_valid   = 1'b1;
    in_rob_idx = 6'(rob);
    in_epoch   = 2'(ep);
    in_prd     = 7'(prd);
    in_uses_rd = uses;
    in_data    = data;
    in_pc      = 32'h1000 + 32'(rob * 4);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || prf_we !== 1'b0 || wake_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outs got ov=%b we=%b wk=%b exp 0 0 0",
               out_valid, prf_we, wake_valid);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    n_cmp++;
    if (drop_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL reset_drop got %h exp 0000", drop_cnt);
    end
    cyc();
    cyc();
    rst = 1'b0;
    #2;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL release_same_cycle_ready got %b exp 0", in_ready);
    end
    cyc();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 5; i++) begin
      drive(i, 0, i + 1, 1'b0, 32'h100 + 32'(i));
      #2;
      n_cmp++;
      if (in_ready !== (i < 4)) begin
        n_err++;
        $display("FAIL b2b_ready[%0d] got %b exp %b", i, in_ready, i < 4);
      end
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_cmp++;
      if (out_valid !== 1'b1 || out_rob_idx !== 6'(i) ||
          out_pc !== 32'h1000 + 32'(i * 4)) begin
        n_err++;
        $display("FAIL b2b_order[%0d] got v=%b rob=%0d pc=%h exp v=1 rob=%0d",
                 i, out_valid, out_rob_idx, out_pc, i);
      end
      cyc();
    end
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drained got %b exp 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_prf_write();
    idle();
    drive(5, 0, 7, 1'b1, 32'hDEAD_BEEF);
    cyc();
    drive(6, 0, 9, 1'b0, 32'h1234_5678);
    cyc();
    in_valid = 1'b0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b1 || prf_we !== 1'b0) begin
      n_err++;
      $display("FAIL prf_hold got v=%b we=%b exp 1 0", out_valid, prf_we);
    end
    out_ready = 1'b1;
    #2;
    n_cmp++;
    if (prf_we !== 1'b1 || prf_waddr !== 7'd7 ||
        prf_wdata !== 32'hDEAD_BEEF || wake_valid !== 1'b1 ||
        wake_pd !== 7'd7) begin
      n_err++;
      $display("FAIL prf_write got we=%b a=%0d d=%h wk=%b pd=%0d exp 1 7 deadbeef 1 7",
               prf_we, prf_waddr, prf_wdata, wake_valid, wake_pd);
    end
    cyc();
    #2;
    n_cmp++;
    if (out_valid !== 1'b1 || out_rob_idx !== 6'd6 ||
        prf_we !== 1'b0 || wake_valid !== 1'b0) begin
      n_err++;
      $display("FAIL prf_no_rd got v=%b rob=%0d we=%b wk=%b exp 1 6 0 0",
               out_valid, out_rob_idx, prf_we, wake_valid);
    end
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_recover();
    idle();
    drive(1, 0, 1, 1'b0, 32'h1);
    cyc();
    drive(2, 0, 2, 1'b0, 32'h2);
    cyc();
    drive(3, 1, 3, 1'b0, 32'h3);
    recover_valid = 1'b1;
    recover_epoch = 2'd1;
    cyc();
    in_valid      = 1'b0;
    recover_valid = 1'b0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rec_silent1 got %b exp 0", out_valid);
    end
    cyc();
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || drop_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL rec_silent2 got v=%b drop=%0d exp 0 1",
               out_valid, drop_cnt);
    end
    cyc();
    #2;
    n_cmp++;
    if (drop_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL rec_drop_cnt got %0d exp 2", drop_cnt);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_rob_idx !== 6'd3 || out_epoch !== 2'd1) begin
      n_err++;
      $display("FAIL rec_present got v=%b rob=%0d ep=%0d exp 1 3 1",
               out_valid, out_rob_idx, out_epoch);
    end
    drive(4, 0, 4, 1'b0, 32'h4);
    cyc();
    in_valid = 1'b0;
    #2;
    n_cmp++;
    if (drop_cnt !== 16'd3 || out_rob_idx !== 6'd3 ||
        dut.count !== 3'd1) begin
      n_err++;
      $display("FAIL stale_in got drop=%0d rob=%0d cnt=%0d exp 3 3 1",
               drop_cnt, out_rob_idx, dut.count);
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive(10 + i, 1, 0, 1'b1, 32'h0);
      cyc();
    end
    drive(20, 1, 0, 1'b1, 32'h0);
    flush_valid = 1'b1;
    out_ready   = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || prf_we !== 1'b0 || wake_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_outs got v=%b we=%b wk=%b exp 0 0 0",
               out_valid, prf_we, wake_valid);
    end
    cyc();
    idle();
    #2;
    n_cmp++;
    if (dut.count !== 3'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty got cnt=%0d v=%b exp 0 0",
               dut.count, out_valid);
    end
    cyc();
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_no_store got v=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_push_pop();
    idle();
    drive(30, 1, 0, 1'b0, 32'h0);
    cyc();
    drive(31, 1, 0, 1'b0, 32'h0);
    cyc();
    drive(32, 1, 0, 1'b0, 32'h0);
    out_ready = 1'b1;
    cyc();
    idle();
    #2;
    n_cmp++;
    if (dut.count !== 3'd2 || out_rob_idx !== 6'd31) begin
      n_err++;
      $display("FAIL push_pop got cnt=%0d rob=%0d exp 2 31",
               dut.count, out_rob_idx);
    end
  endtask

  task automatic test_reset_mid();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre got %b exp 1", out_valid);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || prf_we !== 1'b0 || wake_valid !== 1'b0 ||
        in_ready !== 1'b0 || drop_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL mid_rst got v=%b we=%b wk=%b rdy=%b drop=%0d exp 0 0 0 0 0",
               out_valid, prf_we, wake_valid, in_ready, drop_cnt);
    end
    cyc();
    rst = 1'b0;
    cyc();
    #2;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_release got rdy=%b v=%b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    bit exp_now;
`ifdef WB_RETIRE_QUEUE_BYPASS_EN
    exp_now = 1'b1;
`else
    exp_now = 1'b0;
`endif
    idle();
    out_ready = 1'b1;
    drive(9, 0, 3, 1'b1, 32'hCAFE_0001);
    #2;
    n_cmp++;
    if (out_valid !== exp_now || prf_we !== exp_now) begin
      n_err++;
      $display("FAIL lat_cycle0 got v=%b we=%b exp %b", out_valid, prf_we, exp_now);
    end
    cyc();
    in_valid = 1'b0;
    #2;
    n_cmp++;
    if (out_valid !== !exp_now || dut.count !== 3'(!exp_now)) begin
      n_err++;
      $display("FAIL lat_cycle1 got v=%b cnt=%0d exp %b", out_valid,
               dut.count, !exp_now);
    end
    if (!exp_now) begin
      n_cmp++;
      if (out_rob_idx !== 6'd9 || prf_wdata !== 32'hCAFE_0001) begin
        n_err++;
        $display("FAIL lat_data got rob=%0d d=%h exp 9 cafe0001",
                 out_rob_idx, prf_wdata);
      end
    end
    cyc();
    idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_prf_write();
    test_recover();
    test_flush();
    test_push_pop();
    test_reset_mid();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
